// File: rtl/tank_shell_engine.sv
// Shell-flight engine: debounces the fire/power buttons, animates the shell across
// the 8 digit columns and hands the hit result to the state memory on an active-low strobe.
module tank_shell_engine #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_CYCLES     = 4,
  parameter int unsigned MAX_POWER       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_btn_n,
  input  logic       power_up,
  input  logic       power_down,
  input  logic       turn,
  input  logic [3:0] tank1_location,
  input  logic [3:0] tank2_location,
  input  logic [1:0] tank1_life,
  input  logic [1:0] tank2_life,
  output logic       fire,
  output logic       hit,
  output logic [7:0] shell_pos,
  output logic [2:0] power,
  output logic       busy
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FLIGHT, REPORT, RELEASE} state_t;

  // Debounce: index 2 = fire (idles high), 1 = up, 0 = down
  logic [2:0]      raw, db, flip_c;
  logic [DB_W-1:0] db_cnt [3];
  logic            fire_pulse, up_pulse, down_pulse;

  assign raw = {fire_btn_n, power_up, power_down};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      flip_c[i] = (raw[i] != db[i]) && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db         <= 3'b100;
      fire_pulse <= 1'b0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (raw[i] == db[i] || flip_c[i]) db_cnt[i] <= '0;
        else                              db_cnt[i] <= db_cnt[i] + DB_W'(1);
        if (flip_c[i]) db[i] <= ~db[i];
      end
      fire_pulse <= flip_c[2] & db[2];
      up_pulse   <= flip_c[1] & ~db[1];
      down_pulse <= flip_c[0] & ~db[0];
    end
  end

  // Highest set bit of a location; caller checks for the all-zero case
  function automatic logic [1:0] hi_idx(input logic [3:0] v);
    if (v[3])      hi_idx = 2'd3;
    else if (v[2]) hi_idx = 2'd2;
    else if (v[1]) hi_idx = 2'd1;
    else           hi_idx = 2'd0;
  endfunction

  state_t            state, state_n;
  logic [2:0]        col, col_n, tgt, tgt_n, remaining, rem_n, power_n;
  logic              dir_up, dir_n, rep_cnt, rep_n, hit_n, fire_n, busy_n;
  logic [STEP_W-1:0] step_cnt, step_n;
  logic [7:0]        shell_n;
  logic [2:0]        t1_col_c, t2_col_c;
  logic              last_c, launch_ok_c;

  assign t1_col_c    = {1'b1, hi_idx(tank1_location)};
  assign t2_col_c    = {1'b0, hi_idx(tank2_location)};
  assign launch_ok_c = (|tank1_life) && (|tank2_life) && (|tank1_location) && (|tank2_location);
  assign last_c      = (remaining == 3'd1) || (dir_up && col == 3'd7) || (!dir_up && col == 3'd0);

  always_comb begin
    state_n = state;
    col_n   = col;
    tgt_n   = tgt;
    dir_n   = dir_up;
    rem_n   = remaining;
    step_n  = step_cnt;
    rep_n   = rep_cnt;
    power_n = power;
    hit_n   = hit;
    case (state)
      IDLE: begin
        hit_n = 1'b0;
        if (up_pulse && !down_pulse && power != 3'(MAX_POWER)) power_n = power + 3'd1;
        else if (down_pulse && !up_pulse && power != 3'd1)     power_n = power - 3'd1;
        if (fire_pulse && launch_ok_c) begin
          state_n = FLIGHT;
          dir_n   = turn;
          col_n   = turn ? t2_col_c + 3'd1 : t1_col_c - 3'd1;
          tgt_n   = turn ? t1_col_c : t2_col_c;
          rem_n   = power;
          step_n  = '0;
        end
      end
      FLIGHT: begin
        if (step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
          step_n = '0;
          if (last_c) begin
            state_n = REPORT;
            rep_n   = 1'b0;
            hit_n   = (col == tgt);
          end else begin
            col_n = dir_up ? col + 3'd1 : col - 3'd1;
            rem_n = remaining - 3'd1;
          end
        end else begin
          step_n = step_cnt + STEP_W'(1);
        end
      end
      REPORT: begin
        if (rep_cnt) begin
          state_n = RELEASE;
          hit_n   = 1'b0;
        end else begin
          rep_n = 1'b1;
        end
      end
      RELEASE: begin
        hit_n = 1'b0;
        if (db[2]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Outputs are registered from the next state so they align with the state register
    fire_n  = (state_n != REPORT);
    busy_n  = (state_n != IDLE);
    shell_n = (state_n == FLIGHT || state_n == REPORT) ? (8'b1 << col_n) : 8'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      tgt       <= '0;
      dir_up    <= 1'b0;
      remaining <= '0;
      step_cnt  <= '0;
      rep_cnt   <= 1'b0;
      power     <= 3'd3;
      hit       <= 1'b0;
      fire      <= 1'b1;
      busy      <= 1'b0;
      shell_pos <= '0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      tgt       <= tgt_n;
      dir_up    <= dir_n;
      remaining <= rem_n;
      step_cnt  <= step_n;
      rep_cnt   <= rep_n;
      power     <= power_n;
      hit       <= hit_n;
      fire      <= fire_n;
      busy      <= busy_n;
      shell_pos <= shell_n;
    end
  end

endmodule

// File: tb/tb_tank_shell_engine.sv
// Self-checking bench for tank_shell_engine: directed scenarios plus randomized shots
// compared against a path/hit model built from the shooting rules.
module tb_tank_shell_engine;
  localparam int DEB  = 4;
  localparam int STEP = 2;
  localparam int MAXP = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fire_btn_n = 1'b1, power_up = 1'b0, power_down = 1'b0, turn = 1'b1;
  logic [3:0] tank1_location = 4'b0100, tank2_location = 4'b0010;
  logic [1:0] tank1_life = 2'd3, tank2_life = 2'd3;
  logic       fire, hit, busy;
  logic [7:0] shell_pos;
  logic [2:0] power;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_power = 3;

  always #5 clk = ~clk;

  tank_shell_engine #(.DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(STEP), .MAX_POWER(MAXP)) dut (
    .clk(clk), .rst(rst), .fire_btn_n(fire_btn_n), .power_up(power_up),
    .power_down(power_down), .turn(turn), .tank1_location(tank1_location),
    .tank2_location(tank2_location), .tank1_life(tank1_life), .tank2_life(tank2_life),
    .fire(fire), .hit(hit), .shell_pos(shell_pos), .power(power), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; drive and sample 1 time unit after the edge
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_power(input bit up, input int times);
    for (int i = 0; i < times; i++) begin
      if (up) power_up = 1'b1; else power_down = 1'b1;
      cyc(DEB + 2);
      power_up = 1'b0;
      power_down = 1'b0;
      cyc(DEB + 2);
      if (up) exp_power = (exp_power < MAXP) ? exp_power + 1 : MAXP;
      else    exp_power = (exp_power > 1) ? exp_power - 1 : 1;
    end
    check("power", power, exp_power);
  endtask

  function automatic int hi_bit(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // One fire press; model derives the column path and hit from the rules
  task automatic shoot(input bit hold_fire, input bit poke_up);
    int q[$];
    int shooter, target, dir, c, cnt, it;
    bit valid, seen, exp_hit;
    valid = (tank1_location != 0) && (tank2_location != 0) && (tank1_life != 0) && (tank2_life != 0);
    fire_btn_n = 1'b0;
    if (!valid) begin
      seen = 0;
      repeat (DEB + 6) begin cyc(); if (busy) seen = 1; end
      check("no_launch", seen, 0);
      fire_btn_n = 1'b1;
      cyc(DEB + 2);
      check("power_kept", power, exp_power);
      return;
    end
    shooter = turn ? hi_bit(tank2_location) : hi_bit(tank1_location) + 4;
    target  = turn ? hi_bit(tank1_location) + 4 : hi_bit(tank2_location);
    dir     = turn ? 1 : -1;
    for (int k = 1; k <= exp_power; k++) begin
      c = shooter + dir * k;
      if (c < 0 || c > 7) break;
      q.push_back(c);
    end
    exp_hit = (q[q.size()-1] == target);
    cnt = 0;
    do begin cyc(); cnt++; end while (!busy && cnt < DEB + 12);
    check("launch_latency", cnt, DEB + 1);
    if (!busy) begin fire_btn_n = 1'b1; cyc(DEB + 2); return; end
    if (!hold_fire) fire_btn_n = 1'b1;
    it = 0;
    foreach (q[j]) begin
      for (int s = 0; s < STEP; s++) begin
        if (poke_up && it == 0) power_up = 1'b1;
        if (it == DEB + 1) power_up = 1'b0;
        check($sformatf("shell_c%0d", q[j]), shell_pos, 32'd1 << q[j]);
        check("fire_flight", fire, 1);
        cyc();
        it++;
      end
    end
    power_up = 1'b0;
    for (int r = 0; r < 2; r++) begin
      check("fire_report", fire, 0);
      check("hit_report", hit, exp_hit);
      check("shell_report", shell_pos, 32'd1 << q[q.size()-1]);
      cyc();
    end
    check("fire_release", fire, 1);
    check("hit_release", hit, 0);
    check("shell_release", shell_pos, 0);
    check("busy_release", busy, 1);
    if (hold_fire) begin
      seen = 0;
      repeat (6) begin cyc(); if (!busy || !fire) seen = 1; end
      check("hold_in_release", seen, 0);
      fire_btn_n = 1'b1;
    end
    cnt = 0;
    while (busy && cnt < DEB + 12) begin cyc(); cnt++; end
    check("back_idle", busy, 0);
    if (hold_fire) begin
      seen = 0;
      repeat (DEB + 6) begin cyc(); if (busy) seen = 1; end
      check("no_second_shot", seen, 0);
    end
    check("power_after_shot", power, exp_power);
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    check("rst_fire", fire, 1);
    check("rst_hit", hit, 0);
    check("rst_shell", shell_pos, 0);
    check("rst_power", power, 3);
    check("rst_busy", busy, 0);

    press_power(1, 2);
    shoot(0, 0);                       // cols 2..6, hit
    press_power(0, 1);
    shoot(0, 0);                       // cols 2..5, miss

    turn = 1'b0; tank1_location = 4'b0010; tank2_location = 4'b0001;
    press_power(1, 3);
    shoot(0, 1);                       // cols 4..0, hit, power_up ignored in flight
    tank2_location = 4'b0100;
    shoot(0, 0);                       // cols 4..0, miss

    fire_btn_n = 1'b0;                 // too-short press
    cyc(DEB - 1);
    fire_btn_n = 1'b1;
    begin
      bit seen = 0;
      repeat (DEB + 4) begin cyc(); if (busy) seen = 1; end
      check("short_press", seen, 0);
    end

    press_power(1, 10);
    press_power(0, 10);
    press_power(1, 2);

    tank2_life = 2'd0;
    shoot(0, 0);
    tank2_life = 2'd1;
    turn = 1'b1; tank1_location = 4'b1000; tank2_location = 4'b0001;
    shoot(1, 0);                       // held through report

    fire_btn_n = 1'b0;                 // reset during flight
    begin
      int cnt = 0;
      do begin cyc(); cnt++; end while (!busy && cnt < DEB + 12);
      check("rst_launch", busy, 1);
    end
    fire_btn_n = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_power = 3;
    check("midrst_fire", fire, 1);
    check("midrst_hit", hit, 0);
    check("midrst_shell", shell_pos, 0);
    check("midrst_power", power, 3);
    check("midrst_busy", busy, 0);
    cyc(DEB + 2);

    for (int n = 0; n < 14; n++) begin
      turn           = 1'($urandom_range(0, 1));
      tank1_location = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tank2_location = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tank1_life     = ($urandom_range(0, 5) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      tank2_life     = ($urandom_range(0, 5) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) press_power(1, $urandom_range(0, 3));
      else                           press_power(0, $urandom_range(0, 3));
      shoot(1'($urandom_range(0, 3) == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tank_shell_engine.md
Name: tank_shell_engine

Overview:
Upstream stage of the tank state memory. It debounces the player fire and power buttons, runs the shell-flight animation across the 8 seven-segment digit columns, and decides the hit. It then delivers the result as the active-low `fire` strobe plus `hit`, which the state memory samples on its first `fire`-low cycle. `shell_pos` goes to the display mux, where it is ORed into the segment data.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a raw input must differ from its debounced value before the debounced value flips
STEP_CYCLES, 4, cycles the shell stays on each column
MAX_POWER, 7, upper power limit (range 1..7; power is 3 bits)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fire_btn_n  in  1  raw fire button, active-low
power_up  in  1  raw button, active-high
power_down  in  1  raw button, active-high
turn  in  1  1 = tank2 shoots at tank1; 0 = tank1 shoots at tank2
tank1_location  in  4  one-hot; bits 3/2/1 map to digit columns 7/6/5
tank2_location  in  4  one-hot; bits 2/1/0 map to digit columns 2/1/0
tank1_life  in  2  0 = dead
tank2_life  in  2  0 = dead
fire  out  1  active-low result strobe to the state memory
hit  out  1  hit flag; valid while fire = 0
shell_pos  out  8  one-hot shell column (bit n = digit n); 0 = no shell
power  out  3  current shot power
busy  out  1  1 when not in IDLE

Behaviour:
- Reset (sync, rst = 1), applied in any state:
  - state = IDLE; fire = 1; hit = 0; shell_pos = 0; power = 3; busy = 0.
  - Debounced values: fire = 1, up = 0, down = 0. All debounce counters cleared.
- Debounce, one independent counter per input:
  - The counter increments while raw differs from the debounced value and clears when they match.
  - On reaching DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
  - Edge pulses are one cycle wide, the cycle after the flip.
- Power:
  - Only in IDLE: an up pulse gives power + 1, saturating at MAX_POWER; a down pulse gives power − 1, saturating at 1.
  - Simultaneous up and down pulses: no change.
  - Pulses in any other state are ignored.
- Shooter and target columns, latched at launch:
  - Column index = position of the highest set bit; tank1 adds 4.
  - An all-zero location means no valid column.
- States: IDLE, FLIGHT, REPORT, RELEASE.
  - IDLE → FLIGHT requires all of: debounced fire falling-edge pulse, both lives ≠ 0, and both locations valid. Otherwise stay in IDLE.
  - Latched at launch: dir (turn = 1 → +1, turn = 0 → −1), target column, remaining = power.
  - FLIGHT:
    - The first FLIGHT cycle shows shell_pos = shooter column + dir.
    - Each column is held STEP_CYCLES cycles, then the shell advances and remaining decrements.
    - After the last column's hold → REPORT. The last column is reached when remaining = 1, or at column 0 for dir = −1, or at column 7 for dir = +1.
    - Total flight = (columns traversed) × STEP_CYCLES cycles.
  - REPORT:
    - fire = 0 for exactly 2 cycles.
    - hit = 1 iff the final shell column equals the target column; hit is registered and stable across both cycles.
    - shell_pos holds the final column. → RELEASE.
  - RELEASE:
    - fire = 1, hit = 0, shell_pos = 0.
    - → IDLE once the debounced fire button is high (released). One shot per press.
- Fire presses during FLIGHT, REPORT or RELEASE are ignored.
- Changes to turn, locations or lives after launch are ignored.
- busy = 1 in FLIGHT, REPORT and RELEASE.

Test Plan:
- DEBOUNCE_CYCLES = 4, STEP_CYCLES = 2; tank1 = 0100 (col 6), tank2 = 0010 (col 1), turn = 1. After reset, two power_up presses → power = 5. Fire press → shell_pos = cols 2, 3, 4, 5, 6, each held 2 cycles; then fire = 0 for 2 cycles with hit = 1; then fire = 1 and hit = 0.
- Same setup with power = 4 → final col 5, hit = 0, fire low for 2 cycles.
- Edge truncation: turn = 0, tank1 = 0010 (col 5), power = 7 → cols 4, 3, 2, 1, 0 (10 flight cycles); hit = 1 with tank2 = 0001, hit = 0 with tank2 = 0100.
- Debounce and saturation:
  - fire_btn_n low for 3 cycles → no launch; busy stays 0.
  - 10 power_up presses → power = 7; 10 power_down presses → power = 1.
  - power_up pressed during FLIGHT → power unchanged.
- Guards:
  - tank2_life = 0 → fire press ignored.
  - Fire held low through REPORT → stays in RELEASE until release, with no second shot.
- rst = 1 mid-FLIGHT → next cycle: fire = 1, hit = 0, shell_pos = 0, power = 3, busy = 0.
